// File: rtl/pipe_flowctl_pkg.sv
// Shared definitions for the flow-controlled incrementer pipeline.
// Build option: PIPE_RESET_DATAPATH_EN (see pipelined_incrementer_flowctl).
package pipe_flowctl_pkg;

    function automatic int unsigned occ_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_flowctl_stage.sv
// One pipeline slot: a valid/data register pair with its local ready term.
// Build option: PIPE_RESET_DATAPATH_EN adds a reset to the data register.
module pipe_flowctl_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             down_ready,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // An empty slot can always absorb upstream work, which collapses bubbles.
    assign ready = ~valid | down_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (ready) begin
            valid <= up_valid;
        end
    end

`ifdef PIPE_RESET_DATAPATH_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (ready & up_valid) begin
            data <= up_data;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (ready & up_valid) begin
            data <= up_data;
        end
    end
`endif

endmodule

// File: rtl/pipelined_incrementer_flowctl.sv
// DEPTH-stage out = x + INCR pipeline with valid/ready flow control and occupancy.
// Build option: PIPE_RESET_DATAPATH_EN resets every data register to 0.
module pipelined_incrementer_flowctl
    import pipe_flowctl_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned INCR  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      input_valid,
    output logic                      input_ready,
    input  logic [WIDTH-1:0]          x,
    output logic                      output_valid,
    input  logic                      output_ready,
    output logic [WIDTH-1:0]          out,
    output logic [occ_w(DEPTH)-1:0]   occupancy
);

    localparam int unsigned      OW     = occ_w(DEPTH);
    localparam logic [WIDTH-1:0] INCR_W = WIDTH'(INCR);

    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] data [DEPTH];
    logic [WIDTH-1:0] sum;
    logic             accept;
    logic             retire;

    assign sum = data[0] + INCR_W;

    // Ready terms live per generate block so the backward chain is not one vector.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;
        logic             down_ready;
        logic             stage_ready;

        if (i == 0) begin : g_src
            assign up_valid = input_valid;
            assign up_data  = x;
        end else if (i == 1) begin : g_add
            assign up_valid = valid[0];
            assign up_data  = sum;
        end else begin : g_pass
            assign up_valid = valid[i-1];
            assign up_data  = data[i-1];
        end

        if (i == DEPTH - 1) begin : g_last
            assign down_ready = output_ready;
        end else begin : g_mid
            assign down_ready = g_stage[i+1].stage_ready;
        end

        pipe_flowctl_stage #(.WIDTH(WIDTH)) u_stage (
            .clk        (clk),
            .rst        (rst),
            .up_valid   (up_valid),
            .up_data    (up_data),
            .down_ready (down_ready),
            .ready      (stage_ready),
            .valid      (valid[i]),
            .data       (data[i])
        );
    end

    assign input_ready  = g_stage[0].stage_ready & ~rst;
    assign output_valid = valid[DEPTH-1];
    assign out          = data[DEPTH-1];

    assign accept = input_valid & input_ready;
    assign retire = output_valid & output_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy <= '0;
        end else if (accept & ~retire) begin
            occupancy <= occupancy + OW'(1);
        end else if (retire & ~accept) begin
            occupancy <= occupancy - OW'(1);
        end
    end

endmodule
